oled_spi_arbiter: RTL and testbench

OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

---
 rtl/oled_pkg.sv | 20 ++
 rtl/oled_spi_arbiter_if.sv | 31 +++
 rtl/oled_spi_arbiter_rr_pick.sv | 32 +++
 rtl/oled_spi_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_oled_spi_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI arbiter.
// Holds the arbiter state enum and the panel command bytes.
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Panel command bytes
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] CMD_REMAP       = 8'hA0;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

  // Width of the idle-grant watchdog counter
  localparam int WDOG_W = 16;

endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Bundle of requester-side and SPI-engine-side signals of the arbiter.
// slave modport: the arbiter itself. master modport: whatever drives it.
interface oled_spi_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_dc;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   req_ack;
  logic              spi_ready;
  logic              spi_done;
  logic              spi_start;
  logic [7:0]        spi_d_in;
  logic              cs;
  logic              dc;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  req, req_valid, req_data, req_dc, req_last, spi_ready, spi_done,
    output gnt, req_ack, spi_start, spi_d_in, cs, dc, busy, timeout_err
  );

  modport master (
    output req, req_valid, req_data, req_dc, req_last, spi_ready, spi_done,
    input  gnt, req_ack, spi_start, spi_d_in, cs, dc, busy, timeout_err
  );
endinterface

// File: rtl/oled_spi_arbiter_rr_pick.sv
// Round-robin winner selection, purely combinational.
// Searches req starting at the index after ptr, wrapping, and returns
// the first set bit as a one-hot vector (all zero when req is zero).
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner
);

  int   idx;
  logic found;

  // Walk the requesters in rotated order and keep the first one asking
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_arbiter.sv
// OLED SPI arbiter: shares one SPI byte engine between NREQ requesters.
// Grants are round-robin per burst; cs stays low for the whole burst.
// Optional idle-grant watchdog enabled by defining OLED_ARB_TIMEOUT_EN;
// without it timeout_err is tied low and GRANT waits indefinitely.
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  oled_spi_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("oled_spi_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
  end

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             start_q, start_d;
  logic [7:0]       d_in_q, d_in_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic             last_q, last_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
`ifdef OLED_ARB_TIMEOUT_EN
  logic              tout_q, tout_d;
  logic [WDOG_W-1:0] cnt_q, cnt_d;
`endif

  logic [NREQ-1:0]  winner;
  logic [PTR_W-1:0] win_idx;
  logic             sel_req;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             sel_dc;
  logic             sel_last;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (winner)
  );

  // Encode the one-hot winner as an index for the round-robin pointer
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

  // Route the granted requester's lines to the FSM
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_dc    = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_req   = bus.req[i];
        sel_valid = bus.req_valid[i];
        sel_data  = bus.req_data[8*i +: 8];
        sel_dc    = bus.req_dc[i];
        sel_last  = bus.req_last[i];
      end
    end
  end

  // Next-state and registered-output logic of the arbiter FSM
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    start_d = 1'b0;
    d_in_d  = d_in_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
`ifdef OLED_ARB_TIMEOUT_EN
    tout_d  = tout_q;
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        cs_d  = 1'b1;
        if (|bus.req) begin
          state_d = ST_GRANT;
          gnt_d   = winner;
          win_d   = win_idx;
          cs_d    = 1'b0;
`ifdef OLED_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_GRANT: begin
        if (!sel_req) begin
          // Requester abandoned its burst
          state_d = ST_RELEASE;
          gnt_d   = '0;
          cs_d    = 1'b1;
`ifdef OLED_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (sel_valid && bus.spi_ready) begin
          state_d = ST_XFER;
          start_d = 1'b1;
          ack_d   = gnt_q;
          d_in_d  = sel_data;
          dc_d    = sel_dc;
          last_d  = sel_last;
`ifdef OLED_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
`ifdef OLED_ARB_TIMEOUT_EN
          cnt_d = cnt_q + WDOG_W'(1);
          if (cnt_d >= WDOG_W'(TIMEOUT)) begin
            // Granted requester sat idle too long: reclaim the bus
            state_d = ST_RELEASE;
            gnt_d   = '0;
            cs_d    = 1'b1;
            tout_d  = 1'b1;
            cnt_d   = '0;
          end
`endif
        end
      end

      ST_XFER: begin
        if (bus.spi_done) begin
          if (last_q) begin
            state_d = ST_RELEASE;
            gnt_d   = '0;
            cs_d    = 1'b1;
          end else begin
            state_d = ST_GRANT;
          end
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cs_d    = 1'b1;
        ptr_d   = win_q;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cs_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces cs high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      d_in_q  <= 8'h00;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      last_q  <= 1'b0;
      ptr_q   <= PTR_W'(NREQ - 1);
      win_q   <= '0;
`ifdef OLED_ARB_TIMEOUT_EN
      tout_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      d_in_q  <= d_in_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
`ifdef OLED_ARB_TIMEOUT_EN
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.req_ack   = ack_q;
  assign bus.spi_start = start_q;
  assign bus.spi_d_in  = d_in_q;
  assign bus.cs        = cs_q;
  assign bus.dc        = dc_q;
  assign bus.busy      = (state_q != ST_IDLE);
`ifdef OLED_ARB_TIMEOUT_EN
  assign bus.timeout_err = tout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: per-requester byte queues, a simple SPI
// engine model, and a transaction scoreboard of expected launched bytes
// and grant order, plus per-cycle protocol rules on the outputs.
module tb_oled_spi_arbiter;
  import oled_pkg::*;

  localparam int NREQ = 3;
`ifdef OLED_ARB_TIMEOUT_EN
  localparam int TOUT = 4;
`else
  localparam int TOUT = 255;
`endif
  localparam int ENG_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oled_spi_arbiter_if #(.NREQ(NREQ)) bus ();

  oled_spi_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Requester byte queues: {last, dc, data}
  logic [9:0]      rq [NREQ][$];
  bit              abandon [NREQ];
  bit              novalid [NREQ];
  int              exp_q[$];
  int              exp_gnt[$];
  int              gnt_log[$];
  int              eng_cnt;
  int              rel_cnt;
  logic [8:0]      last_sent;
  logic [NREQ-1:0] prev_gnt;
  int              n_checks;
  int              n_err;

  function automatic logic [9:0] ent(input bit last, input bit dcf, input logic [7:0] d);
    return {last, dcf, d};
  endfunction

  function automatic int xe(input int src, input bit dcf, input logic [7:0] d);
    return src * 512 + (dcf ? 256 : 0) + int'(d);
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_drive();
    logic [9:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() != 0) begin
        e = rq[i][0];
        bus.req[i]            = 1'b1;
        bus.req_valid[i]      = !novalid[i];
        bus.req_data[8*i +: 8] = e[7:0];
        bus.req_dc[i]         = e[8];
        bus.req_last[i]       = e[9];
      end else begin
        bus.req[i]            = 1'b0;
        bus.req_valid[i]      = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_dc[i]         = 1'b0;
        bus.req_last[i]       = 1'b0;
      end
    end
    bus.spi_ready = (eng_cnt == 0);
  endtask

  // One clock: check outputs, advance the SPI engine and the requesters
  task automatic tick();
    int got;
    @(negedge clk);
    if (reset) last_sent = 9'h000;
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
    chk("cs_vs_gnt", 32'(bus.cs), 32'(~|bus.gnt));
    chk("busy_when_granted", 32'(bus.busy | ~|bus.gnt), 1);
    chk("ack_vs_start", 32'(bus.req_ack), bus.spi_start ? 32'(bus.gnt) : 32'd0);
`ifndef OLED_ARB_TIMEOUT_EN
    chk("timeout_err_low", 32'(bus.timeout_err), 0);
`endif
    if (bus.spi_start) begin
      chk("start_granted", 32'(|bus.gnt), 1);
      got = xe(idx_of(bus.gnt), bus.dc, bus.spi_d_in);
      if (exp_q.size() == 0) chk("unexpected_start", got, 32'hFFFF_FFFF);
      else chk("spi_byte", got, exp_q.pop_front());
      last_sent = {bus.dc, bus.spi_d_in};
    end
    chk("d_dc_hold", 32'({bus.dc, bus.spi_d_in}), 32'(last_sent));
    if (bus.gnt != '0 && prev_gnt == '0) gnt_log.push_back(idx_of(bus.gnt));
    prev_gnt = bus.gnt;
    if (bus.busy && bus.gnt == '0) rel_cnt++;
    bus.spi_done = 1'b0;
    if (reset) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) bus.spi_done = 1'b1;
      end
      if (bus.spi_start) eng_cnt = ENG_LAT;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      if (abandon[i] && bus.gnt[i]) begin
        rq[i].delete();
        abandon[i] = 1'b0;
      end
    end
    apply_drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      abandon[i] = 1'b0;
      novalid[i] = 1'b0;
    end
    exp_q.delete();
    exp_gnt.delete();
    gnt_log.delete();
    rel_cnt = 0;
    eng_cnt = 0;
    last_sent = 9'h000;
    prev_gnt = '0;
    bus.spi_done = 1'b0;
    apply_drive();
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_ack", 32'(bus.req_ack), 0);
    chk("rst_start", 32'(bus.spi_start), 0);
    chk("rst_d_in", 32'(bus.spi_d_in), 0);
    chk("rst_cs", 32'(bus.cs), 1);
    chk("rst_dc", 32'(bus.dc), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
  endtask

  task automatic go();
    apply_drive();
    reset = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(all_empty() && !bus.busy && eng_cnt == 0) && n < budget);
    if (n >= budget) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_budget: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic finish_scn(input string name, input int exp_rel);
    chk({name, "_unsent"}, exp_q.size(), 0);
    chk({name, "_ngrants"}, gnt_log.size(), exp_gnt.size());
    for (int i = 0; i < exp_gnt.size() && i < gnt_log.size(); i++)
      chk({name, "_grant"}, gnt_log[i], exp_gnt[i]);
    chk({name, "_release"}, rel_cnt, exp_rel);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_err    = 0;
    eng_cnt  = 0;

    // Single 2-byte burst from requester 0
    do_reset();
    rq[0].push_back(ent(0, 0, CMD_DISPLAY_ON));
    rq[0].push_back(ent(1, 0, 8'h00));
    exp_q.push_back(xe(0, 0, 8'hAF));
    exp_q.push_back(xe(0, 0, 8'h00));
    exp_gnt.push_back(0);
    go();
    run_idle(200, "burst2");
    finish_scn("burst2", 1);

    // Fairness: all three request from reset, requester 0 has two bursts
    do_reset();
    rq[0].push_back(ent(1, 0, 8'h01));
    rq[0].push_back(ent(1, 0, 8'h04));
    rq[1].push_back(ent(1, 0, 8'h02));
    rq[2].push_back(ent(1, 1, 8'h03));
    exp_q.push_back(xe(0, 0, 8'h01));
    exp_q.push_back(xe(1, 0, 8'h02));
    exp_q.push_back(xe(2, 1, 8'h03));
    exp_q.push_back(xe(0, 0, 8'h04));
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_gnt.push_back(2); exp_gnt.push_back(0);
    go();
    run_idle(400, "fair");
    finish_scn("fair", 4);

    // Mixed D/C burst from requester 2 (pointer wraps from reset value)
    do_reset();
    rq[2].push_back(ent(0, 0, CMD_REMAP));
    rq[2].push_back(ent(1, 1, 8'h55));
    exp_q.push_back(xe(2, 0, 8'hA0));
    exp_q.push_back(xe(2, 1, 8'h55));
    exp_gnt.push_back(2);
    go();
    run_idle(200, "mixdc");
    finish_scn("mixdc", 1);

    // Abandon: requester 1 drops req while granted
    do_reset();
    rq[0].push_back(ent(1, 0, 8'h21));
    rq[1].push_back(ent(1, 0, 8'h22));
    rq[2].push_back(ent(1, 0, 8'h23));
    abandon[1] = 1'b1;
    exp_q.push_back(xe(0, 0, 8'h21));
    exp_q.push_back(xe(2, 0, 8'h23));
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    go();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.gnt[1] && n < 200);
    chk("abandon_granted", 32'(bus.gnt[1]), 1);
    tick();
    chk("abandon_cs", 32'(bus.cs), 1);
    chk("abandon_gnt", 32'(bus.gnt), 0);
    chk("abandon_start", 32'(bus.spi_start), 0);
    run_idle(200, "abandon");
    finish_scn("abandon", 3);

    // Reset during XFER of 0x12, after an earlier burst moved the pointer
    do_reset();
    rq[0].push_back(ent(1, 0, 8'h11));
    rq[0].push_back(ent(0, 0, 8'h12));
    rq[0].push_back(ent(1, 0, 8'h34));
    exp_q.push_back(xe(0, 0, 8'h11));
    exp_q.push_back(xe(0, 0, 8'h12));
    go();
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.spi_start && bus.spi_d_in == 8'h12) && n < 300);
    chk("xfer_launched", 32'(bus.spi_d_in), 32'h12);
    chk("xfer_pre_unsent", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1;
    chk("xfer_rst_cs", 32'(bus.cs), 1);
    chk("xfer_rst_gnt", 32'(bus.gnt), 0);
    chk("xfer_rst_busy", 32'(bus.busy), 0);
    chk("xfer_rst_d_in", 32'(bus.spi_d_in), 0);
    do_reset();
    rq[0].push_back(ent(1, 0, 8'h31));
    rq[1].push_back(ent(1, 1, 8'h32));
    exp_q.push_back(xe(0, 0, 8'h31));
    exp_q.push_back(xe(1, 1, 8'h32));
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    go();
    run_idle(300, "post_rst");
    finish_scn("post_rst", 2);

`ifdef OLED_ARB_TIMEOUT_EN
    // Watchdog: granted requester never presents a valid byte
    do_reset();
    rq[0].push_back(ent(1, 0, CMD_DISPLAY_OFF));
    novalid[0] = 1'b1;
    go();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.gnt[0] && n < 50);
    n = 1;
    tick();
    while (bus.gnt[0] && n < 50) begin
      n++;
      tick();
    end
    chk("wdog_grant_cycles", n, 4);
    chk("wdog_release_busy", 32'(bus.busy), 1);
    chk("wdog_err_set", 32'(bus.timeout_err), 1);
    rq[0].delete();
    novalid[0] = 1'b0;
    apply_drive();
    for (int i = 0; i < 3; i++) tick();
    chk("wdog_err_sticky", 32'(bus.timeout_err), 1);
    chk("wdog_idle", 32'(bus.busy), 0);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
